// File: rtl/y86_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// y86_mem_arbiter_if
// Bundles the three buses that meet at the Y86 memory arbiter:
//   fetch side   : f_req, f_addr        -> f_ack, f_rdata, f_err
//   data side    : d_req, d_icode, d_valA, d_valE, d_valP
//                                       -> d_ack, d_valM, d_err
//   memory side  : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Modports:
//   slave  - the arbiter itself (consumes requests, drives the memory strobe)
//   master - the environment (fetch/memory stages and the data RAM)
// ----------------------------------------------------------------------------
interface y86_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              f_req;
    logic [63:0]       f_addr;
    logic              f_ack;
    logic [63:0]       f_rdata;
    logic              f_err;

    logic              d_req;
    logic [3:0]        d_icode;
    logic [63:0]       d_valA;
    logic [63:0]       d_valE;
    logic [63:0]       d_valP;
    logic              d_ack;
    logic [63:0]       d_valM;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_icode, d_valA, d_valE, d_valP, mem_rdata,
        output f_ack, f_rdata, f_err, d_ack, d_valM, d_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_icode, d_valA, d_valE, d_valP, mem_rdata,
        input  f_ack, f_rdata, f_err, d_ack, d_valM, d_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/y86_mem_arbiter.sv
// ----------------------------------------------------------------------------
// y86_mem_arbiter
// Shares one single-port 64-bit data memory between the Y86 fetch stage
// (read only) and the memory stage (rmmovq/mrmovq/pushq/popq/call/ret).
// One access is outstanding at a time: IDLE grants a requester, ACCESS
// strobes the memory and waits MEM_LAT cycles for read data, RESP pulses
// the granted side's ack with its data/error.  Out-of-range addresses and
// non-memory icodes skip ACCESS and answer one cycle after the grant.
// Ports:
//   clk    - clock, all state on the rising edge
//   reset  - synchronous, active-high; abandons any access in flight
//   bus    - y86_mem_arbiter_if.slave (fetch, data and memory buses)
// ----------------------------------------------------------------------------
module y86_mem_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    y86_mem_arbiter_if.slave      bus
);

    localparam int CNT_W = $clog2(MEM_LAT + 1) + 1;
    localparam int STK_W = $clog2(STARVE_LIM + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);
    localparam logic [STK_W-1:0] STK_LIM  = STK_W'(STARVE_LIM);
    localparam logic [63:0]      DEPTH64  = 64'(DEPTH);

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

    stateT              state_q,  state_d;
    logic [STK_W-1:0]   streak_q, streak_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               isData_q, isData_d;
    logic               we_q,     we_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [63:0]        wdata_q,  wdata_d;
    logic               err_q,    err_d;
    logic [63:0]        fRdata_q, fRdata_d;
    logic [63:0]        dValM_q,  dValM_d;

    logic               grantData;
    logic               grantFetch;
    logic               reqMem;
    logic               reqWe;
    logic [63:0]        reqAddr;
    logic [63:0]        reqWdata;
    logic               strobe;

    // State register; reset drops any access in flight without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
            cnt_q    <= '0;
            isData_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            fRdata_q <= '0;
            dValM_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            cnt_q    <= cnt_d;
            isData_q <= isData_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            fRdata_q <= fRdata_d;
            dValM_q  <= dValM_d;
        end
    end

    // Arbitration, icode decode and next-state logic.  The data side wins
    // unless fetch has already watched STARVE_LIM data grants go by.  The
    // address compare uses all 64 bits so high-bit garbage cannot alias
    // into the memory.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        cnt_d    = cnt_q;
        isData_d = isData_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        fRdata_d = fRdata_q;
        dValM_d  = dValM_q;

        grantData  = bus.d_req && !(bus.f_req && (streak_q == STK_LIM));
        grantFetch = bus.f_req && !grantData;

        reqMem   = 1'b0;
        reqWe    = 1'b0;
        reqAddr  = '0;
        reqWdata = '0;
        if (grantData) begin
            case (bus.d_icode)
                I_RMMOVQ, I_PUSHQ: begin
                    reqMem = 1'b1; reqWe = 1'b1;
                    reqAddr = bus.d_valE; reqWdata = bus.d_valA;
                end
                I_CALL: begin
                    reqMem = 1'b1; reqWe = 1'b1;
                    reqAddr = bus.d_valE; reqWdata = bus.d_valP;
                end
                I_MRMOVQ: begin
                    reqMem = 1'b1; reqAddr = bus.d_valE;
                end
                I_POPQ, I_RET: begin
                    reqMem = 1'b1; reqAddr = bus.d_valA;
                end
                default: reqMem = 1'b0;
            endcase
        end else begin
            reqMem  = 1'b1;
            reqAddr = bus.f_addr;
        end

        case (state_q)
            IDLE: begin
                if (grantData || grantFetch) begin
                    isData_d = grantData;
                    if (grantData && bus.f_req)
                        streak_d = (streak_q == STK_LIM) ? streak_q : streak_q + STK_W'(1);
                    else
                        streak_d = '0;
                    we_d    = reqWe;
                    addr_d  = reqAddr[ADDR_W-1:0];
                    wdata_d = reqWdata;
                    cnt_d   = '0;
                    if (!reqMem || (reqAddr >= DEPTH64)) begin
                        err_d   = reqMem;
                        state_d = RESP;
                        if (grantData) dValM_d = '0;
                        else           fRdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                    if (isData_q) dValM_d = we_q ? 64'd0 : bus.mem_rdata;
                    else          fRdata_d = bus.mem_rdata;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The strobe and its address/data are only driven on the first ACCESS
    // cycle; the remaining ACCESS cycles just wait out the read latency.
    assign strobe        = (state_q == ACCESS) && (cnt_q == '0);
    assign bus.mem_en    = strobe;
    assign bus.mem_we    = strobe && we_q;
    assign bus.mem_addr  = strobe ? addr_q  : '0;
    assign bus.mem_wdata = strobe ? wdata_q : '0;

    assign bus.f_ack   = (state_q == RESP) && !isData_q;
    assign bus.f_err   = (state_q == RESP) && !isData_q && err_q;
    assign bus.f_rdata = fRdata_q;
    assign bus.d_ack   = (state_q == RESP) && isData_q;
    assign bus.d_err   = (state_q == RESP) && isData_q && err_q;
    assign bus.d_valM  = dValM_q;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_y86_mem_arbiter
// Two arbiters share clock and reset: dutA (MEM_LAT=1) backed by a writable
// 1024-word RAM model, dutB (MEM_LAT=3) backed by a read-only pattern RAM
// whose word at index a is 0xB000_0000_0000_0000 | a.  Inputs change on the
// falling edge and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_y86_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    y86_mem_arbiter_if #(.ADDR_W(10)) busA ();
    y86_mem_arbiter_if #(.ADDR_W(10)) busB ();

    y86_mem_arbiter #(.DEPTH(1024), .ADDR_W(10), .MEM_LAT(1), .STARVE_LIM(4))
        dutA (.clk(clk), .reset(reset), .bus(busA));
    y86_mem_arbiter #(.DEPTH(1024), .ADDR_W(10), .MEM_LAT(3), .STARVE_LIM(4))
        dutB (.clk(clk), .reset(reset), .bus(busB));

    // RAM model for dutA: words start as 0xA5A5_0000_0000_0000 + index,
    // read data is valid exactly one cycle after the strobe, junk otherwise.
    logic [63:0] memA [0:1023];
    bit          memLoaded = 1'b0;
    logic [63:0] pipeA = '0;
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 1024; i++) memA[i] <= 64'hA5A5_0000_0000_0000 + 64'(i);
            memLoaded <= 1'b1;
        end else if (busA.mem_en && busA.mem_we) begin
            memA[busA.mem_addr] <= busA.mem_wdata;
        end
        pipeA <= (busA.mem_en && !busA.mem_we) ? memA[busA.mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    end
    assign busA.mem_rdata = pipeA;

    // Read-only pattern RAM for dutB with a three-cycle read pipeline.
    logic [63:0] pipeB [3];
    always @(posedge clk) begin
        pipeB[0] <= (busB.mem_en && !busB.mem_we)
                    ? (64'hB000_0000_0000_0000 | 64'(busB.mem_addr)) : 64'hBAD0_BAD0_BAD0_BAD0;
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign busB.mem_rdata = pipeB[2];

    // Drives one request on dutA, holds it until the matching ack (bounded),
    // and reports what was seen: latency in cycles (-1 on timeout), returned
    // data/error, strobe count, cycle and contents of the last strobe, and
    // how many acks arrived on the wrong side.
    task automatic applyStimulus(input bit isD, input logic [3:0] ic,
                                 input logic [63:0] vA, input logic [63:0] vE,
                                 input logic [63:0] vP, input logic [63:0] fA,
                                 output int lat, output logic [63:0] data, output logic err,
                                 output int strobes, output int strobeAt, output logic sWe,
                                 output logic [9:0] sAddr, output logic [63:0] sWdata,
                                 output int wrongAck);
        bit got;
        got = 1'b0; lat = 0; data = '0; err = 1'b0; strobes = 0; strobeAt = -1;
        sWe = 1'b0; sAddr = '0; sWdata = '0; wrongAck = 0;
        @(negedge clk);
        if (isD) begin
            busA.d_req = 1'b1; busA.d_icode = ic;
            busA.d_valA = vA; busA.d_valE = vE; busA.d_valP = vP;
        end else begin
            busA.f_req = 1'b1; busA.f_addr = fA;
        end
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busA.mem_en) begin
                strobes++; strobeAt = lat;
                sWe = busA.mem_we; sAddr = busA.mem_addr; sWdata = busA.mem_wdata;
            end
            if (isD ? busA.f_ack : busA.d_ack) wrongAck++;
            if (isD ? busA.d_ack : busA.f_ack) begin
                got = 1'b1;
                data = isD ? busA.d_valM : busA.f_rdata;
                err  = isD ? busA.d_err  : busA.f_err;
            end
        end
        busA.d_req = 1'b0;
        busA.f_req = 1'b0;
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if ({busA.f_ack, busA.f_err, busA.d_ack, busA.d_err} !== 4'b0) begin
            bad++; $display("[TB] FAIL reset_acks: got=%b want=0000", {busA.f_ack, busA.f_err, busA.d_ack, busA.d_err}); end
        total++; if ({busA.mem_en, busA.mem_we, busA.mem_addr} !== 12'h0) begin
            bad++; $display("[TB] FAIL reset_mem: got=%h want=000", {busA.mem_en, busA.mem_we, busA.mem_addr}); end
        total++; if ({busA.f_rdata, busA.d_valM, busA.mem_wdata} !== 192'h0) begin
            bad++; $display("[TB] FAIL reset_data: got=%h want=0", {busA.f_rdata, busA.d_valM, busA.mem_wdata}); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int lat, st, sAt, wr; logic [63:0] data, sWd; logic err, sWe; logic [9:0] sA;
        applyStimulus(1'b1, 4'h4, 64'hDEAD, 64'd5, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL wr_lat: got=%0d want=3", lat); end
        total++; if (st !== 1 || sAt !== 1) begin bad++; $display("[TB] FAIL wr_strobe: got=%0d@%0d want=1@1", st, sAt); end
        total++; if ({sWe, sA, sWd} !== {1'b1, 10'd5, 64'hDEAD}) begin
            bad++; $display("[TB] FAIL wr_bus: got=%b/%0d/%h want=1/5/dead", sWe, sA, sWd); end
        total++; if (data !== 64'd0 || err !== 1'b0) begin bad++; $display("[TB] FAIL wr_resp: got=%h/%b want=0/0", data, err); end
        applyStimulus(1'b1, 4'h5, 64'd0, 64'd5, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL rd_lat: got=%0d want=3", lat); end
        total++; if ({sWe, sA} !== {1'b0, 10'd5}) begin bad++; $display("[TB] FAIL rd_bus: got=%b/%0d want=0/5", sWe, sA); end
        total++; if (data !== 64'hDEAD || err !== 1'b0) begin bad++; $display("[TB] FAIL rd_resp: got=%h/%b want=dead/0", data, err); end
        total++; if (wr !== 0) begin bad++; $display("[TB] FAIL rd_wrong_ack: got=%0d want=0", wr); end
        @(negedge clk);
        total++; if (busA.d_ack !== 1'b0 || busA.d_valM !== 64'hDEAD) begin
            bad++; $display("[TB] FAIL idle_hold: got=%b/%h want=0/dead", busA.d_ack, busA.d_valM); end
    endtask

    task automatic test_fetch();
        int lat, st, sAt, wr; logic [63:0] data, sWd; logic err, sWe; logic [9:0] sA;
        applyStimulus(1'b0, 4'h0, 64'd0, 64'd0, 64'd0, 64'd5, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (lat !== 3 || data !== 64'hDEAD || err !== 1'b0) begin
            bad++; $display("[TB] FAIL fetch5: got=%0d/%h/%b want=3/dead/0", lat, data, err); end
        total++; if (wr !== 0) begin bad++; $display("[TB] FAIL fetch_wrong_ack: got=%0d want=0", wr); end
        applyStimulus(1'b0, 4'h0, 64'd0, 64'd0, 64'd0, 64'd1023, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (data !== 64'hA5A5_0000_0000_03FF || err !== 1'b0) begin
            bad++; $display("[TB] FAIL fetch1023: got=%h/%b want=a5a50000000003ff/0", data, err); end
    endtask

    task automatic test_call_ret();
        int lat, st, sAt, wr; logic [63:0] data, sWd; logic err, sWe; logic [9:0] sA;
        applyStimulus(1'b1, 4'h8, 64'h999, 64'd127, 64'h40, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if ({sWe, sA, sWd} !== {1'b1, 10'd127, 64'h40}) begin
            bad++; $display("[TB] FAIL call_bus: got=%b/%0d/%h want=1/127/40", sWe, sA, sWd); end
        applyStimulus(1'b1, 4'h9, 64'd127, 64'd3, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (data !== 64'h40 || err !== 1'b0 || lat !== 3) begin
            bad++; $display("[TB] FAIL ret: got=%h/%b/%0d want=40/0/3", data, err, lat); end
    endtask

    task automatic test_push_pop();
        int lat, st, sAt, wr; logic [63:0] data, sWd; logic err, sWe; logic [9:0] sA;
        applyStimulus(1'b1, 4'hA, 64'h1234, 64'd200, 64'h77, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if ({sWe, sA, sWd} !== {1'b1, 10'd200, 64'h1234}) begin
            bad++; $display("[TB] FAIL push_bus: got=%b/%0d/%h want=1/200/1234", sWe, sA, sWd); end
        applyStimulus(1'b1, 4'hB, 64'd200, 64'd9, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (data !== 64'h1234 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL pop: got=%h/%b want=1234/0", data, err); end
    endtask

    task automatic test_starvation();
        string order;
        int cyc;
        order = "";
        cyc = 0;
        @(negedge clk);
        busA.f_req = 1'b1; busA.f_addr = 64'd10;
        busA.d_req = 1'b1; busA.d_icode = 4'h5; busA.d_valE = 64'd20;
        while (order.len() < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busA.d_ack && busA.f_ack) order = {order, "X"};
            else if (busA.d_ack)          order = {order, "D"};
            else if (busA.f_ack)          order = {order, "F"};
        end
        busA.f_req = 1'b0;
        busA.d_req = 1'b0;
        total++; if (order != "DDDDFDDDDF") begin
            bad++; $display("[TB] FAIL starve_order: got=%s want=DDDDFDDDDF", order); end
    endtask

    task automatic test_addr_error();
        int lat, st, sAt, wr; logic [63:0] data, sWd; logic err, sWe; logic [9:0] sA;
        applyStimulus(1'b1, 4'h5, 64'd0, 64'd1024, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (lat !== 1 || err !== 1'b1 || data !== 64'd0 || st !== 0) begin
            bad++; $display("[TB] FAIL d_oob: got=%0d/%b/%h/%0d want=1/1/0/0", lat, err, data, st); end
        applyStimulus(1'b0, 4'h0, 64'd0, 64'd0, 64'd0, 64'h8000_0000_0000_0000, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (lat !== 1 || err !== 1'b1 || data !== 64'd0 || st !== 0) begin
            bad++; $display("[TB] FAIL f_oob: got=%0d/%b/%h/%0d want=1/1/0/0", lat, err, data, st); end
        applyStimulus(1'b1, 4'h4, 64'h77, 64'h1_0000_0005, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (err !== 1'b1 || st !== 0) begin
            bad++; $display("[TB] FAIL wr_high_bits: got=%b/%0d want=1/0", err, st); end
    endtask

    task automatic test_nonmem();
        int lat, st, sAt, wr; logic [63:0] data, sWd; logic err, sWe; logic [9:0] sA;
        applyStimulus(1'b1, 4'h5, 64'd0, 64'd5, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (data !== 64'hDEAD) begin bad++; $display("[TB] FAIL rd5_after_oob: got=%h want=dead", data); end
        applyStimulus(1'b1, 4'h6, 64'd0, 64'd5, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (lat !== 1 || err !== 1'b0 || data !== 64'd0 || st !== 0) begin
            bad++; $display("[TB] FAIL opq: got=%0d/%b/%h/%0d want=1/0/0/0", lat, err, data, st); end
    endtask

    task automatic test_latency3();
        int n, sAt; bit got; logic [63:0] data;
        n = 0; sAt = -1; got = 1'b0; data = '0;
        @(negedge clk);
        busB.d_req = 1'b1; busB.d_icode = 4'h9; busB.d_valA = 64'd77; busB.d_valE = 64'd3;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (busB.mem_en) sAt = n;
            if (busB.d_ack) begin got = 1'b1; data = busB.d_valM; end
        end
        busB.d_req = 1'b0;
        total++; if (!got || n !== 5) begin bad++; $display("[TB] FAIL lat3_ack: got=%b@%0d want=1@5", got, n); end
        total++; if (sAt !== 1) begin bad++; $display("[TB] FAIL lat3_strobe: got=%0d want=1", sAt); end
        total++; if (data !== 64'hB000_0000_0000_004D) begin
            bad++; $display("[TB] FAIL lat3_data: got=%h want=b00000000000004d", data); end
    endtask

    task automatic test_reset_mid_access();
        int lat, st, sAt, wr, acks; logic [63:0] data, sWd; logic err, sWe; logic [9:0] sA;
        applyStimulus(1'b1, 4'h5, 64'd0, 64'd5, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        @(negedge clk);
        busA.d_req = 1'b1; busA.d_icode = 4'h5; busA.d_valE = 64'd5;
        @(negedge clk);
        total++; if (busA.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_strobe: got=%b want=1", busA.mem_en); end
        reset = 1'b1;
        busA.d_req = 1'b0;
        @(negedge clk);
        total++; if ({busA.d_ack, busA.f_ack, busA.mem_en, busA.mem_we, busA.d_err, busA.f_err} !== 6'b0) begin
            bad++; $display("[TB] FAIL mid_reset_ctl: got=%b want=000000",
                            {busA.d_ack, busA.f_ack, busA.mem_en, busA.mem_we, busA.d_err, busA.f_err}); end
        total++; if ({busA.d_valM, busA.f_rdata, busA.mem_addr, busA.mem_wdata} !== 202'h0) begin
            bad++; $display("[TB] FAIL mid_reset_data: got=%h want=0", {busA.d_valM, busA.f_rdata, busA.mem_addr, busA.mem_wdata}); end
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busA.d_ack || busA.f_ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("[TB] FAIL abandoned_ack: got=%0d want=0", acks); end
        applyStimulus(1'b1, 4'h5, 64'd0, 64'd5, 64'd0, 64'd0, lat, data, err, st, sAt, sWe, sA, sWd, wr);
        total++; if (lat !== 3 || data !== 64'hDEAD || err !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset_rd: got=%0d/%h/%b want=3/dead/0", lat, data, err); end
    endtask

    // Top-level sequence; each scenario task does its own checking.
    initial begin
        busA.f_req = 1'b0; busA.f_addr = '0; busA.d_req = 1'b0; busA.d_icode = '0;
        busA.d_valA = '0; busA.d_valE = '0; busA.d_valP = '0;
        busB.f_req = 1'b0; busB.f_addr = '0; busB.d_req = 1'b0; busB.d_icode = '0;
        busB.d_valA = '0; busB.d_valE = '0; busB.d_valP = '0;
        test_reset();
        test_write_read();
        test_fetch();
        test_call_ret();
        test_push_pop();
        test_starvation();
        test_addr_error();
        test_nonmem();
        test_latency3();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guards against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
